// File: rtl/dvi_pkg.sv
// Shared constants for the DVI transmitter: TMDS control tokens, default
// 640x480@60 timing and the TMDS clock-channel word.
package dvi_pkg;

    localparam logic [9:0] CTRL_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_11 = 10'b1010101011;

    localparam logic [9:0] CLK_PATTERN = 10'b0000011111;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    function automatic logic [9:0] ctrl_token(input logic [1:0] c);
        case (c)
            2'b00:   return CTRL_00;
            2'b01:   return CTRL_01;
            2'b10:   return CTRL_10;
            default: return CTRL_11;
        endcase
    endfunction

endpackage

// File: rtl/dvi_tx_core_tmds_encoder.sv
// TMDS 8b/10b encoder: transition-minimising stage, DC-balancing stage with
// a signed running disparity, and control tokens during blanking.
module tmds_encoder
    import dvi_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       de,
    input  logic [1:0] c,
    input  logic [7:0] d,
    output logic [9:0] q
);

    logic [3:0]        n1d;
    logic [3:0]        n1q;
    logic              use_xnor;
    logic [8:0]        qm;
    logic signed [5:0] cnt;
    logic signed [5:0] cnt_nx;
    logic signed [5:0] bal;
    logic [9:0]        q_nx;

    always_comb begin
        n1d = '0;
        for (int i = 0; i < 8; i++) n1d = n1d + 4'(d[i]);
        use_xnor = (n1d > 4'd4) || (n1d == 4'd4 && !d[0]);

        qm    = '0;
        qm[0] = d[0];
        for (int i = 1; i < 8; i++)
            qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = ~use_xnor;

        n1q = '0;
        for (int i = 0; i < 8; i++) n1q = n1q + 4'(qm[i]);
        // bal = ones minus zeros of qm[7:0]
        bal = $signed({1'b0, n1q, 1'b0}) - 6'sd8;

        if (cnt == 6'sd0 || bal == 6'sd0) begin
            q_nx   = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            cnt_nx = qm[8] ? cnt + bal : cnt - bal;
        end else if ((cnt > 6'sd0 && bal > 6'sd0) || (cnt < 6'sd0 && bal < 6'sd0)) begin
            q_nx   = {1'b1, qm[8], ~qm[7:0]};
            cnt_nx = cnt + $signed({4'b0, qm[8], 1'b0}) - bal;
        end else begin
            q_nx   = {1'b0, qm[8], qm[7:0]};
            cnt_nx = cnt - $signed({4'b0, ~qm[8], 1'b0}) + bal;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q   <= '0;
            cnt <= '0;
        end else if (en) begin
            if (de) begin
                q   <= q_nx;
                cnt <= cnt_nx;
            end else begin
                q   <= ctrl_token(c);
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/dvi_tx_core.sv
// DVI 1.0 transmitter on the bit clock: timing generator, three TMDS
// encoders and 10:1 serializers. DVI_TEST_PATTERN_EN swaps RGB for colour bars.
module dvi_tx_core
    import dvi_pkg::*;
#(
    parameter int   H_ACTIVE   = DEF_H_ACTIVE,
    parameter int   H_FP       = DEF_H_FP,
    parameter int   H_SYNC     = DEF_H_SYNC,
    parameter int   H_BP       = DEF_H_BP,
    parameter int   V_ACTIVE   = DEF_V_ACTIVE,
    parameter int   V_FP       = DEF_V_FP,
    parameter int   V_SYNC     = DEF_V_SYNC,
    parameter int   V_BP       = DEF_V_BP,
    parameter logic H_SYNC_POL = 1'b0,
    parameter logic V_SYNC_POL = 1'b0
) (
    input  logic       serial_clk_i,
    input  logic       rst_ni,
    input  logic [7:0] red_i,
    input  logic [7:0] green_i,
    input  logic [7:0] blue_i,
    output logic       tmds_clk_p,
    output logic       tmds_clk_n,
    output logic [2:0] tmds_data_p,
    output logic [2:0] tmds_data_n
);

    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [3:0]       div_cnt;
    logic             pix_tick;
    logic [9:0]       h;
    logic [9:0]       v;
    logic             de;
    logic             hsync;
    logic             vsync;
    logic [2:0][7:0]  pix_d;
    logic [2:0][1:0]  ctl;
    logic [2:0][9:0]  word;
    logic [2:0][9:0]  sh;
    logic [9:0]       clk_sh;

    assign pix_tick = (div_cnt == 4'd9);

    always_ff @(posedge serial_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_cnt <= '0;
            h       <= '0;
            v       <= '0;
        end else begin
            div_cnt <= pix_tick ? 4'd0 : div_cnt + 4'd1;
            if (pix_tick) begin
                if (h == H_LAST) begin
                    h <= '0;
                    v <= (v == V_LAST) ? 10'd0 : v + 10'd1;
                end else begin
                    h <= h + 10'd1;
                end
            end
        end
    end

    assign de    = (h < 10'(H_ACTIVE)) && (v < 10'(V_ACTIVE));
    assign hsync = (h >= HS_START && h <= HS_END) ? H_SYNC_POL : ~H_SYNC_POL;
    assign vsync = (v >= VS_START && v <= VS_END) ? V_SYNC_POL : ~V_SYNC_POL;

`ifdef DVI_TEST_PATTERN_EN
    logic [2:0] bar;
    logic       unused_rgb;
    // Eight equal-width bars across the active line
    assign bar        = 3'(h / 10'(H_ACTIVE / 8));
    assign unused_rgb = ^{red_i, green_i, blue_i};
    assign pix_d[2]   = {8{bar[2]}};
    assign pix_d[1]   = {8{bar[1]}};
    assign pix_d[0]   = {8{bar[0]}};
`else
    assign pix_d[2] = red_i;
    assign pix_d[1] = green_i;
    assign pix_d[0] = blue_i;
`endif

    assign ctl[0] = {vsync, hsync};
    assign ctl[1] = 2'b00;
    assign ctl[2] = 2'b00;

    for (genvar gi = 0; gi < 3; gi++) begin : g_ch
        tmds_encoder u_enc (
            .clk   (serial_clk_i),
            .rst_n (rst_ni),
            .en    (pix_tick),
            .de    (de),
            .c     (ctl[gi]),
            .d     (pix_d[gi]),
            .q     (word[gi])
        );
        assign tmds_data_p[gi] = sh[gi][0];
    end

    // Words load one tick after they are encoded; shifted out LSB first
    always_ff @(posedge serial_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sh     <= '0;
            clk_sh <= '0;
        end else if (pix_tick) begin
            sh     <= word;
            clk_sh <= CLK_PATTERN;
        end else begin
            for (int i = 0; i < 3; i++) sh[i] <= {1'b0, sh[i][9:1]};
            clk_sh <= {1'b0, clk_sh[9:1]};
        end
    end

    assign tmds_clk_p  = clk_sh[0];
    assign tmds_clk_n  = ~clk_sh[0];
    assign tmds_data_n = ~tmds_data_p;

endmodule

// File: tb/tb_dvi_tx_core.sv
// Scoreboard bench for dvi_tx_core: a bit-level TMDS model predicts each
// pixel's three words; serial output is deserialised and compared.
module tb_dvi_tx_core;

    logic       clk;
    logic       rst_n;
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
    logic       clk_p;
    logic       clk_n;
    logic [2:0] data_p;
    logic [2:0] data_n;

    dvi_tx_core dut (
        .serial_clk_i (clk),
        .rst_ni       (rst_n),
        .red_i        (red),
        .green_i      (green),
        .blue_i       (blue),
        .tmds_clk_p   (clk_p),
        .tmds_clk_n   (clk_n),
        .tmds_data_p  (data_p),
        .tmds_data_n  (data_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0][9:0] w;
        string           tag;
    } exp_t;

    exp_t            sb[$];
    int              checks = 0;
    int              errors = 0;
    int              ecnt   = 0;
    int              n_pushed = 0;
    int              k_pix  = 0;
    int              cnt_m[3];
    logic [2:0][9:0] acc_p;
    logic [2:0][9:0] acc_n;
    logic [9:0]      clk_word = 10'b0000011111;

    task automatic enc(input logic [7:0] d, input logic de, input logic [1:0] c,
                       input int cin, output logic [9:0] wd, output int cout);
        int n1, a, z;
        logic xn;
        logic [8:0] qm;
        n1 = $countones(d);
        xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = !xn;
        a = $countones(qm[7:0]);
        z = 8 - a;
        if (!de) begin
            case (c)
                2'b00: wd = 10'b1101010100;
                2'b01: wd = 10'b0010101011;
                2'b10: wd = 10'b0101010100;
                default: wd = 10'b1010101011;
            endcase
            cout = 0;
        end else if (cin == 0 || a == z) begin
            wd   = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            cout = qm[8] ? cin + a - z : cin + z - a;
        end else if ((cin > 0 && a > z) || (cin < 0 && z > a)) begin
            wd   = {1'b1, qm[8], ~qm[7:0]};
            cout = cin + (qm[8] ? 2 : 0) + z - a;
        end else begin
            wd   = {1'b0, qm[8], qm[7:0]};
            cout = cin - (qm[8] ? 0 : 2) + a - z;
        end
    endtask

    task automatic drive_px(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        int h, v, co;
        logic de, hs, vs;
        logic [7:0] dr, dg, db;
        exp_t e;
        h  = k_pix % 800;
        v  = (k_pix / 800) % 525;
        de = (h < 640) && (v < 480);
        hs = (h >= 656 && h <= 751) ? 1'b0 : 1'b1;
        vs = (v >= 490 && v <= 491) ? 1'b0 : 1'b1;
`ifdef DVI_TEST_PATTERN_EN
        dr = ((h / 80) & 4) != 0 ? 8'hFF : 8'h00;
        dg = ((h / 80) & 2) != 0 ? 8'hFF : 8'h00;
        db = ((h / 80) & 1) != 0 ? 8'hFF : 8'h00;
`else
        dr = r; dg = g; db = b;
`endif
        enc(db, de, {vs, hs}, cnt_m[0], e.w[0], co); cnt_m[0] = co;
        enc(dg, de, 2'b00,    cnt_m[1], e.w[1], co); cnt_m[1] = co;
        enc(dr, de, 2'b00,    cnt_m[2], e.w[2], co); cnt_m[2] = co;
        e.tag = "px";
        sb.push_back(e);
        n_pushed++;
        k_pix++;
        red = r; green = g; blue = b;
    endtask

    task automatic sample();
        int j, w;
        exp_t e;
        logic ce;
        ce = (ecnt < 10) ? 1'b0 : clk_word[(ecnt - 10) % 10];
        checks++;
        assert (clk_p === ce) else begin
            errors++; $error("FAIL clk_p cyc %0d got %b want %b", ecnt, clk_p, ce);
        end
        checks++;
        assert (clk_n === ~ce) else begin
            errors++; $error("FAIL clk_n cyc %0d got %b want %b", ecnt, clk_n, ~ce);
        end
        if (ecnt >= 20) begin
            j = (ecnt - 20) % 10;
            for (int c = 0; c < 3; c++) begin
                acc_p[c][j] = data_p[c];
                acc_n[c][j] = data_n[c];
            end
            w = (ecnt - 20) / 10;
            if (j == 9 && w < n_pushed && sb.size() > 0) begin
                e = sb.pop_front();
                for (int c = 0; c < 3; c++) begin
                    checks++;
                    assert (acc_p[c] === e.w[c]) else begin
                        errors++; $error("FAIL %s pix %0d ch %0d p got %h want %h", e.tag, w, c, acc_p[c], e.w[c]);
                    end
                    checks++;
                    assert (acc_n[c] === ~e.w[c]) else begin
                        errors++; $error("FAIL %s pix %0d ch %0d n got %h want %h", e.tag, w, c, acc_n[c], ~e.w[c]);
                    end
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        ecnt++;
        @(negedge clk);
        sample();
    endtask

    task automatic check_reset(input string tag);
        checks++;
        assert (data_p === 3'b000) else begin errors++; $error("FAIL %s data_p got %b want 000", tag, data_p); end
        checks++;
        assert (data_n === 3'b111) else begin errors++; $error("FAIL %s data_n got %b want 111", tag, data_n); end
        checks++;
        assert (clk_p === 1'b0) else begin errors++; $error("FAIL %s clk_p got %b want 0", tag, clk_p); end
        checks++;
        assert (clk_n === 1'b1) else begin errors++; $error("FAIL %s clk_n got %b want 1", tag, clk_n); end
    endtask

    task automatic restart();
        sb.delete();
        n_pushed = 0;
        k_pix    = 0;
        ecnt     = 0;
        for (int c = 0; c < 3; c++) cnt_m[c] = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        red = '0; green = '0; blue = '0;
        restart();
        repeat (3) begin
            @(negedge clk);
            check_reset("reset");
        end

        // Line 0 from pixel 0, then the start of line 1
        drive_px(8'h00, 8'h00, 8'h00);
        sb[$].w = {10'h100, 10'h100, 10'h100}; sb[$].tag = "zero";
        rst_n = 1'b1;
        repeat (10) cycle();
        for (int k = 1; k < 810; k++) begin
            if (k == 1)
                drive_px(8'h00, 8'h00, 8'h00);
            else
                drive_px(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            if (k == 640) begin
                sb[$].w = {10'b1101010100, 10'b1101010100, 10'b1010101011}; sb[$].tag = "blank640";
            end
            if (k == 656) begin
                sb[$].w = {10'b1101010100, 10'b1101010100, 10'b0101010100}; sb[$].tag = "blank656";
            end
            repeat (10) cycle();
        end
        repeat (30) cycle();
        checks++;
        assert (sb.size() == 0) else begin errors++; $error("FAIL drain left %0d want 0", sb.size()); end

        // Asynchronous reset between edges, then a fresh line
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset("async_rst");
        restart();
        repeat (3) @(negedge clk);
        check_reset("rst_hold");
        drive_px(8'h00, 8'h00, 8'hFF);
`ifdef DVI_TEST_PATTERN_EN
        sb[$].w = {10'h100, 10'h100, 10'h100}; sb[$].tag = "pat_ignore";
`else
        sb[$].w = {10'h100, 10'h100, 10'h200}; sb[$].tag = "full";
`endif
        rst_n = 1'b1;
        repeat (10) cycle();
        for (int k = 1; k < 90; k++) begin
            drive_px(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            repeat (10) cycle();
        end
        repeat (30) cycle();
        checks++;
        assert (sb.size() == 0) else begin errors++; $error("FAIL drain2 left %0d want 0", sb.size()); end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
